// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up at the final step.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [1:0]      state_dbg
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_count;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_addend;
    logic [XLEN-1:0]   r_a;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_div0;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_ma;
    logic [XLEN-1:0]   w_mb;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic              w_div_ok;
    logic [XLEN-1:0]   w_div_diff;
    logic [XLEN-1:0]   w_hi_nxt;
    logic [XLEN-1:0]   w_lo_nxt;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_final;

    // a is signed for MUL/MULH/MULHSU/DIV/REM; b only for MUL/MULH/DIV/REM
    assign w_sa = a[XLEN-1] & (funct3[2] ? ~funct3[0] : (funct3 != 3'b011));
    assign w_sb = b[XLEN-1] & (funct3[2] ? ~funct3[0] : ~funct3[1]);
    assign w_ma = w_sa ? -a : a;
    assign w_mb = w_sb ? -b : b;

    always_comb begin
        w_mul_sum   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_addend}) : {1'b0, r_hi};
        w_div_shift = {r_hi, r_lo[XLEN-1]};
        w_div_ok    = (w_div_shift >= {1'b0, r_addend});
        w_div_diff  = w_div_shift[XLEN-1:0] - r_addend;
        if (r_op[2]) begin
            w_hi_nxt = w_div_ok ? w_div_diff : w_div_shift[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_div_ok};
        end else begin
            w_hi_nxt = w_mul_sum[XLEN:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end
        w_prod_s = r_neg_q ? -{w_hi_nxt, w_lo_nxt} : {w_hi_nxt, w_lo_nxt};
        w_quo_s  = r_neg_q ? -w_lo_nxt : w_lo_nxt;
        w_rem_s  = r_neg_r ? -w_hi_nxt : w_hi_nxt;
        case (r_op)
            3'b000:         w_final = w_prod_s[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         w_final = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101: w_final = r_div0 ? '1 : w_quo_s;
            default:        w_final = r_div0 ? r_a : w_rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_addend <= '0;
            r_a      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_BUSY: begin
                    r_hi    <= w_hi_nxt;
                    r_lo    <= w_lo_nxt;
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(XLEN - 1)) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_final;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // multiply keeps the multiplier in r_lo; divide keeps the dividend there
                        r_state  <= S_BUSY;
                        r_busy   <= 1'b1;
                        r_count  <= '0;
                        r_op     <= funct3;
                        r_hi     <= '0;
                        r_lo     <= funct3[2] ? w_ma : w_mb;
                        r_addend <= funct3[2] ? w_mb : w_ma;
                        r_a      <= a;
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_div0   <= (b == '0);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign state_dbg = r_state;
endmodule
